uart_frame_rx: RTL and testbench

Receive-side counterpart of the framed 32-bit UART link used by the FPGA test harness. Deserialises 8/N/1 bytes from the FTDI TX line and hunts for frames of the form 0x55, four payload bytes (little-endian), 0xAA. Reassembles each frame into a 32-bit word and presents it with a one-cycle valid strobe. Sits directly behind the `ftdi_txd` pin, feeding host commands into test logic.

---
 rtl/uart_frame_rx.sv | 197 +++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// 8/N/1 UART receiver with a frame parser: 0x55, four little-endian payload
// bytes, 0xAA. Each good frame yields one 32-bit word with a one-cycle valid.
module uart_frame_rx #(
    parameter int CLK_FREQ     = 25000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ftdi_txd,
    output logic [31:0] data,
    output logic        valid,
    output logic        err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW           = $clog2(TO_LIMIT + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TO_LIMIT);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_RECOVER
    } rx_state_t;

    typedef enum logic [2:0] {
        FR_HUNT,
        FR_B0,
        FR_B1,
        FR_B2,
        FR_B3,
        FR_TAIL
    } fr_state_t;

    typedef struct packed {
        rx_state_t rx;
        fr_state_t fr;
    } dbg_t;

    logic            rx_meta;
    logic            rxs;
    rx_state_t       rx_state;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_byte;
    logic            byte_stb;
    logic            byte_err;
    fr_state_t       fr_state;
    logic [31:0]     shift;
    logic [TW-1:0]   to_cnt;
    dbg_t            dbg;

    // Combined state view for external checkers; both FSMs decode through it.
    assign dbg = '{rx: rx_state, fr: fr_state};

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= ftdi_txd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= 3'd0;
            rx_byte  <= 8'h00;
            byte_stb <= 1'b0;
            byte_err <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            byte_err <= 1'b0;
            case (dbg.rx)
                RX_IDLE: begin
                    if (!rxs) begin
                        bit_cnt  <= HALF_LOAD;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (rxs) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        bit_cnt  <= FULL_LOAD;
                        bit_idx  <= 3'd0;
                        rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        rx_byte <= {rxs, rx_byte[7:1]};
                        bit_cnt <= FULL_LOAD;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (rxs) begin
                        byte_stb <= 1'b1;
                        rx_state <= RX_IDLE;
                    end else begin
                        byte_err <= 1'b1;
                        rx_state <= RX_RECOVER;
                    end
                end
                RX_RECOVER: begin
                    if (rxs) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Byte events outrank the timeout; the counter restarts on every good byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            fr_state <= FR_HUNT;
            shift    <= 32'h0;
            data     <= 32'h0;
            valid    <= 1'b0;
            err      <= 1'b0;
            to_cnt   <= '0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (byte_err) begin
                err      <= 1'b1;
                fr_state <= FR_HUNT;
                to_cnt   <= '0;
            end else if (byte_stb) begin
                to_cnt <= '0;
                case (dbg.fr)
                    FR_HUNT: begin
                        if (rx_byte == 8'h55) begin
                            fr_state <= FR_B0;
                        end
                    end
                    FR_B0: begin
                        shift[7:0] <= rx_byte;
                        fr_state   <= FR_B1;
                    end
                    FR_B1: begin
                        shift[15:8] <= rx_byte;
                        fr_state    <= FR_B2;
                    end
                    FR_B2: begin
                        shift[23:16] <= rx_byte;
                        fr_state     <= FR_B3;
                    end
                    FR_B3: begin
                        shift[31:24] <= rx_byte;
                        fr_state     <= FR_TAIL;
                    end
                    FR_TAIL: begin
                        if (rx_byte == 8'hAA) begin
                            data  <= shift;
                            valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        fr_state <= FR_HUNT;
                    end
                    default: fr_state <= FR_HUNT;
                endcase
            end else if (dbg.fr == FR_HUNT) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_MAX) begin
                err      <= 1'b1;
                fr_state <= FR_HUNT;
                to_cnt   <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: table of framed byte streams, randomized streams
// against a byte-level frame model, plus glitch, timeout and reset sequences.
module tb_uart_frame_rx;
    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int TO_BITS  = 32;
    localparam int TO_CYC   = TO_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line = 1'b1;
    logic [31:0] data;
    logic        valid;
    logic        err;

    uart_frame_rx #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .TIMEOUT_BITS (TO_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ftdi_txd (line),
        .data     (data),
        .valid    (valid),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          err_cnt   = 0;
    int          err_cyc   = 0;
    int          excl_bad  = 0;
    int          data_bad  = 0;
    logic [31:0] prev_data = 32'h0;

    always @(negedge clk) begin
        if (valid) got_q.push_back(data);
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (valid && err) excl_bad++;
        if (!rst && !valid && data !== prev_data) data_bad++;
        prev_data = data;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycles=%0d limit=90000", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Bit 8 set: stop bit held low for two bit-times.
    task automatic send_byte(input logic [8:0] b);
        line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (b[8]) begin
            line = 1'b0;
            repeat (2 * CPB) @(negedge clk);
        end
        line = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        line = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic start_case();
        got_q.delete();
        exp_q.delete();
        err_cnt = 0;
    endtask

    task automatic check_case(input string tag, input int exp_err);
        chk({tag, "_nvalid"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_nerr"}, err_cnt, exp_err);
        if (exp_q.size() > 0) chk({tag, "_data"}, data, exp_q[exp_q.size() - 1]);
    endtask

    // Byte-stream view of the protocol; a trailing partial frame times out.
    task automatic model(input logic [8:0] seq[$], output int nerr);
        int          phase;
        logic [31:0] w;
        nerr  = 0;
        phase = 0;
        w     = 32'h0;
        foreach (seq[i]) begin
            if (seq[i][8]) begin
                nerr++;
                phase = 0;
            end else if (phase == 0) begin
                if (seq[i][7:0] == 8'h55) phase = 1;
            end else if (phase <= 4) begin
                w[8*(phase-1) +: 8] = seq[i][7:0];
                phase++;
            end else begin
                if (seq[i][7:0] == 8'hAA) exp_q.push_back(w);
                else nerr++;
                phase = 0;
            end
        end
        if (phase != 0) nerr++;
    endtask

    typedef struct {
        logic [8:0]  b[$];
        int          nv;
        logic [31:0] w0;
        logic [31:0] w1;
        int          ne;
    } vec_t;

    vec_t vt[4];

    initial begin
        logic [8:0] seq[$];
        int         nerr;
        int         t0;
        int         delta;

        vt[0].b = '{9'h055, 9'h0EF, 9'h0BE, 9'h0AD, 9'h0DE, 9'h0AA};
        vt[0].nv = 1; vt[0].w0 = 32'hDEADBEEF; vt[0].w1 = 32'h0; vt[0].ne = 0;
        vt[1].b = '{9'h000, 9'h013, 9'h055, 9'h001, 9'h002, 9'h003, 9'h004, 9'h0AA,
                    9'h055, 9'h0AA, 9'h055, 9'h0AA, 9'h055, 9'h0AA};
        vt[1].nv = 2; vt[1].w0 = 32'h04030201; vt[1].w1 = 32'h55AA55AA; vt[1].ne = 0;
        vt[2].b = '{9'h055, 9'h044, 9'h033, 9'h022, 9'h011, 9'h0AA,
                    9'h055, 9'h001, 9'h002, 9'h003, 9'h004, 9'h000,
                    9'h055, 9'h078, 9'h056, 9'h034, 9'h012, 9'h0AA};
        vt[2].nv = 2; vt[2].w0 = 32'h11223344; vt[2].w1 = 32'h12345678; vt[2].ne = 1;
        vt[3].b = '{9'h055, 9'h001, 9'h002, 9'h103,
                    9'h055, 9'h00A, 9'h00B, 9'h00C, 9'h00D, 9'h0AA};
        vt[3].nv = 1; vt[3].w0 = 32'h0D0C0B0A; vt[3].w1 = 32'h0; vt[3].ne = 1;

        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_data", data, 32'h0);
        chk("reset_valid", {31'h0, valid}, 32'h0);
        chk("reset_err", {31'h0, err}, 32'h0);
        rst = 1'b0;
        idle_bits(2);

        for (int k = 0; k < 4; k++) begin
            start_case();
            if (vt[k].nv >= 1) exp_q.push_back(vt[k].w0);
            if (vt[k].nv >= 2) exp_q.push_back(vt[k].w1);
            foreach (vt[k].b[j]) send_byte(vt[k].b[j]);
            idle_bits(36);
            check_case($sformatf("table%0d", k), vt[k].ne);
        end

        // Short low pulse on an idle line.
        start_case();
        line = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        idle_bits(4);
        check_case("glitch", 0);

        for (int r = 0; r < 6; r++) begin
            start_case();
            seq.delete();
            for (int f = 0; f < 2; f++) begin
                repeat ($urandom_range(0, 2)) seq.push_back({1'b0, 8'($urandom_range(0, 255))});
                seq.push_back(9'h055);
                for (int p = 0; p < 4; p++) begin
                    case ($urandom_range(0, 9))
                        0:       seq.push_back(9'h055);
                        1:       seq.push_back(9'h0AA);
                        2:       seq.push_back({1'b1, 8'($urandom_range(0, 255))});
                        default: seq.push_back({1'b0, 8'($urandom_range(0, 255))});
                    endcase
                end
                if ($urandom_range(0, 3) == 0) seq.push_back({1'b0, 8'($urandom_range(0, 255))});
                else seq.push_back(9'h0AA);
            end
            model(seq, nerr);
            foreach (seq[j]) begin
                send_byte(seq[j]);
                idle_bits($urandom_range(0, 1));
            end
            idle_bits(36);
            check_case($sformatf("rand%0d", r), nerr);
        end

        // Inter-byte timeout inside a frame.
        start_case();
        send_byte(9'h055);
        send_byte(9'h001);
        send_byte(9'h002);
        t0 = cyc;
        idle_bits(40);
        delta = err_cyc - t0;
        chk("timeout_nerr", err_cnt, 1);
        chk("timeout_nvalid", got_q.size(), 0);
        chk("timeout_window", {31'h0, (delta >= TO_CYC - CPB) && (delta <= TO_CYC + CPB)}, 32'h1);
        start_case();
        exp_q.push_back(32'h0D0C0B0A);
        seq = '{9'h055, 9'h00A, 9'h00B, 9'h00C, 9'h00D, 9'h0AA};
        foreach (seq[j]) send_byte(seq[j]);
        idle_bits(4);
        check_case("after_timeout", 0);

        // Reset pulse during payload byte 2.
        start_case();
        send_byte(9'h055);
        send_byte(9'h011);
        fork
            begin
                send_byte(9'h022);
                send_byte(9'h033);
                send_byte(9'h044);
                send_byte(9'h0AA);
            end
            begin
                repeat (CPB * 4 + CPB / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("midrst_data", data, 32'h0);
                chk("midrst_valid", {31'h0, valid}, 32'h0);
                chk("midrst_err", {31'h0, err}, 32'h0);
                #1 rst = 1'b0;
            end
        join
        idle_bits(40);
        chk("midrst_no_valid", got_q.size(), 0);
        start_case();
        exp_q.push_back(32'h87654321);
        seq = '{9'h055, 9'h021, 9'h043, 9'h065, 9'h087, 9'h0AA};
        foreach (seq[j]) send_byte(seq[j]);
        idle_bits(4);
        check_case("after_rst", 0);

        chk("valid_err_exclusive", excl_bad, 0);
        chk("data_only_on_valid", data_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
